// File: rtl/alu_operand_stage.sv
// ALU operand stage: each channel takes one operand from a source select
// (zero, PC, PC+4, register, immediate forms, or the shared XMM fixed-point
// value converted to fp32). Handshakes on both sides are valid/ready: a
// transfer happens on a rising clock edge where valid and ready are both
// high, and valid is never withdrawn before that edge.
// The fp32 converter normalises one bit per cycle and is shared by all
// channels. The FSM state is exported on dbg_state.
module alu_operand_stage #(
    parameter int NUM_PORTS = 2,
    parameter int XS_WIDTH  = 64,
    parameter int FRAC_BITS = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3*NUM_PORTS-1:0]    src,
    input  logic [31:0]               instr_addr,
    input  logic [31:0]               instr,
    input  logic [32*NUM_PORTS-1:0]   rs_data,
    input  logic [XS_WIDTH-1:0]       xs_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*NUM_PORTS-1:0]   data,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_num_ports
        $error("alu_operand_stage: NUM_PORTS must be in 1..4");
    end
    if (127 + XS_WIDTH - 1 - FRAC_BITS > 254 || 127 - FRAC_BITS < 1) begin : g_bad_exp_range
        $error("alu_operand_stage: XS_WIDTH/FRAC_BITS put the fp32 exponent out of range");
    end

    // Exponent of an operand whose leading one sits in the MSB position.
    localparam logic [7:0] EXP_INIT = 8'(127 + XS_WIDTH - 1 - FRAC_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [32*NUM_PORTS-1:0]   r_data;
    logic [NUM_PORTS-1:0]      r_sel110;
    logic                      r_sign;
    logic [XS_WIDTH-1:0]       r_mag;
    logic [7:0]                r_exp;

    logic [32*NUM_PORTS-1:0]   w_next_data;
    logic [NUM_PORTS-1:0]      w_sel110;
    logic                      w_accept;
    logic                      w_conv;
    logic [XS_WIDTH-1:0]       w_abs;
    logic [XS_WIDTH+21:0]      w_mant_ext;
    logic [22:0]               w_mant;
    logic [31:0]               w_fp32;
    logic                      w_unused_instr;

    // The low opcode bits never reach an operand.
    assign w_unused_instr = ^instr[6:0];

    assign w_accept = in_valid && in_ready;
    // A conversion is only needed when some channel wants it and the value
    // is nonzero; zero goes straight to DONE as +0.0.
    assign w_conv   = (|w_sel110) && (|xs_data);
    // Two's-complement magnitude; the most negative value maps to 2^(W-1).
    assign w_abs    = xs_data[XS_WIDTH-1] ? (~xs_data + 1'b1) : xs_data;

    // Mantissa is the 23 bits just below the (now normalised) leading one;
    // zero fill on the right covers narrow operands, truncation rounds
    // toward zero.
    assign w_mant_ext = {r_mag[XS_WIDTH-2:0], 23'd0};
    assign w_mant     = 23'(w_mant_ext >> (XS_WIDTH - 1));
    assign w_fp32     = {r_sign, r_exp, w_mant};

    assign data      = r_data;
    assign dbg_state = r_state;

    // Per-channel operand mux; 110 channels are zero until the converter finishes.
    always_comb begin
        w_next_data = '0;
        w_sel110    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            case (src[3*k +: 3])
                3'b000:  w_next_data[32*k +: 32] = 32'd0;
                3'b001:  w_next_data[32*k +: 32] = instr_addr + 32'd4;
                3'b010:  w_next_data[32*k +: 32] = instr_addr;
                3'b011:  w_next_data[32*k +: 32] = rs_data[32*k +: 32];
                3'b100:  w_next_data[32*k +: 32] = {{20{instr[31]}}, instr[31:20]};
                3'b101:  w_next_data[32*k +: 32] = {instr[31:12], 12'd0};
                3'b110: begin
                    w_sel110[k]              = 1'b1;
                    w_next_data[32*k +: 32]  = 32'd0;
                end
                default: w_next_data[32*k +: 32] = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = w_conv ? ST_NORM : ST_DONE;
                end
            end
            ST_NORM: begin
                busy = 1'b1;
                if (r_mag[XS_WIDTH-1]) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_next_state = w_conv ? ST_NORM : ST_DONE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, normalise in NORM, then drop the fp32 result into every 110 channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_sel110 <= '0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= 8'd0;
        end else if (w_accept) begin
            r_data   <= w_next_data;
            r_sel110 <= w_sel110;
            r_sign   <= xs_data[XS_WIDTH-1];
            r_mag    <= w_abs;
            r_exp    <= EXP_INIT;
        end else if (r_state == ST_NORM) begin
            if (!r_mag[XS_WIDTH-1]) begin
                r_mag <= r_mag << 1;
                r_exp <= r_exp - 8'd1;
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (r_sel110[k]) begin
                        r_data[32*k +: 32] <= w_fp32;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed cases plus randomized traffic,
// checked by a queue-based scoreboard fed from a fixed-point to fp32
// reference model.
module tb_alu_operand_stage;
    localparam int NP = 2;
    localparam int XW = 64;
    localparam int FB = 15;
    localparam int DW = 32 * NP;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3*NP-1:0] src;
    logic [31:0]     instr_addr;
    logic [31:0]     instr;
    logic [DW-1:0]   rs_data;
    logic [XW-1:0]   xs_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   data;
    logic            busy;
    logic [1:0]      dbg_state;

    alu_operand_stage #(.NUM_PORTS(NP), .XS_WIDTH(XW), .FRAC_BITS(FB)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src(src), .instr_addr(instr_addr), .instr(instr), .rs_data(rs_data),
        .xs_data(xs_data), .out_valid(out_valid), .out_ready(out_ready),
        .data(data), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int            lat_q[$];
    int            acc_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Value = xs / 2^FB. Locate the leading one, the exponent follows from
    // its position, the mantissa is the following 23 bits (truncated).
    function automatic void fp_model(input logic [63:0] xs, output logic [31:0] f, output int lat);
        logic        sgn;
        logic [63:0] mag;
        logic [63:0] frac;
        logic [63:0] m;
        int          p;
        int          e;
        f   = 32'd0;
        lat = 0;
        if (xs != 64'd0) begin
            sgn = xs[63];
            mag = sgn ? (64'd0 - xs) : xs;
            p   = 0;
            for (int i = 0; i < 64; i++) if (mag[i]) p = i;
            e    = 127 + p - FB;
            frac = mag & ~(64'd1 << p);
            m    = (p >= 23) ? (frac >> (p - 23)) : (frac << (23 - p));
            f    = {sgn, e[7:0], m[22:0]};
            lat  = 64 - p;
        end
    endfunction

    function automatic logic [31:0] model_ch(input logic [2:0] s, input logic [31:0] pc,
                                             input logic [31:0] ins, input logic [31:0] rs,
                                             input logic [31:0] fp);
        logic [11:0] imm;
        case (s)
            3'd0: return 32'd0;
            3'd1: return pc + 32'd4;
            3'd2: return pc;
            3'd3: return rs;
            3'd4: begin imm = ins[31:20]; return 32'($signed(imm)); end
            3'd5: return ins & 32'hFFFF_F000;
            3'd6: return fp;
            default: begin imm = {ins[31:25], ins[11:7]}; return 32'($signed(imm)); end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic scramble();
        src        = 6'($urandom);
        instr_addr = $urandom;
        instr      = $urandom;
        rs_data    = {$urandom, $urandom};
        xs_data    = {$urandom, $urandom};
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [3*NP-1:0] s, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [DW-1:0] rs, input logic [XW-1:0] xs, output int wcyc);
        logic [DW-1:0] e;
        logic [31:0]   fp;
        int            lat;
        bit            any6;
        bit            got;
        src = s; instr_addr = pc; instr = ins; rs_data = rs; xs_data = xs;
        in_valid = 1'b1;
        fp_model(xs, fp, lat);
        any6 = 1'b0;
        for (int k = 0; k < NP; k++) begin
            e[32*k +: 32] = model_ch(s[3*k +: 3], pc, ins, rs[32*k +: 32], fp);
            if (s[3*k +: 3] == 3'd6) any6 = 1'b1;
        end
        got  = 1'b0;
        wcyc = 0;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(any6 ? lat : 0);
                acc_q.push_back(cyc + 1);
                got = 1'b1;
            end else begin
                wcyc++;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 64'(got), 64'd1);
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit            new_res;
        int            pres;
        logic [DW-1:0] ed;
        int            el;
        int            ea;
        new_res = 1'b1;
        pres    = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                new_res = 1'b1;
            end else begin
                if (out_valid && new_res) begin
                    new_res = 1'b0;
                    pres    = cyc;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_valid: got out_valid=1 data=%h expected no result", data);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() > 0) begin
                        ed = exp_q.pop_front();
                        el = lat_q.pop_front();
                        ea = acc_q.pop_front();
                        chk("result_data", 64'(data), 64'(ed));
                        chk("result_latency", 64'(pres - ea), 64'(el));
                    end
                    new_res = 1'b1;
                end
            end
        end
    end

    // ---------------- random out_ready ----------------
    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int            w;
        logic [DW-1:0] held;
        bit            saw;
        logic [XW-1:0] xs;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        src = '0; instr_addr = '0; instr = '0; rs_data = '0; xs_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        reset = 1'b0;

        // First edge after reset release accepts; register and PC+4 operands.
        send(6'b001_011, 32'h0000_1000, 32'd0, {32'h1111_2222, 32'hDEAD_BEEF}, 64'd0, w);
        chk("first_accept_wait", 64'(w), 64'd0);
        drain();

        // Immediate forms.
        send(6'b101_100, 32'h0, 32'hFFF0_0000, 64'd0, 64'd0, w);
        send(6'b010_111, 32'h0000_2468, 32'hFE00_0FA3, 64'd0, 64'd0, w);
        drain();

        // Conversions: 1.0, -2.0, most negative value, zero.
        send(6'b000_110, 32'h0, 32'h0, 64'd0, 64'h0000_0000_0000_8000, w);
        @(negedge clk);
        chk("busy_in_conv", 64'(busy), 64'd1);
        chk("no_valid_in_conv", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        drain();
        send(6'b110_110, 32'h0, 32'h0, 64'd0, 64'hFFFF_FFFF_FFFF_0000, w);
        send(6'b011_110, 32'h0, 32'h0, {32'hCAFE_F00D, 32'h0}, 64'h8000_0000_0000_0000, w);
        send(6'b110_001, 32'h0000_0100, 32'h0, 64'd0, 64'd0, w);
        drain();

        // Stall in DONE while all inputs wander, then back-to-back accept.
        out_ready = 1'b0;
        send(6'b010_011, 32'h0000_4000, 32'h0, {32'h0, 32'h1357_9BDF}, 64'd0, w);
        saw = 1'b0;
        for (int t = 0; t < 20 && !saw; t++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("stall_valid_seen", 64'(saw), 64'd1);
        held = data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            scramble();
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_data_hold", 64'(data), 64'(held));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(6'b001_001, 32'hFFFF_FFFC, 32'h0, 64'd0, 64'd0, w);
        chk("b2b_accept_wait", 64'(w), 64'd0);
        drain();

        // Reset in the middle of a long conversion.
        send(6'b000_110, 32'h0, 32'h0, 64'd0, 64'h0000_0000_0000_8000, w);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_data", 64'(data), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete(); lat_q.delete(); acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        saw = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("post_rst_quiet", 64'(saw), 64'd0);
        @(posedge clk); #1;
        send(6'b110_011, 32'h0, 32'h0, {32'h0, 32'h0BAD_CAFE}, 64'h0000_0000_0003_8000, w);
        drain();

        // Random traffic with random back-pressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: xs = 64'd0;
                1: xs = {$urandom, $urandom};
                2: xs = {$urandom, $urandom} >> $urandom_range(0, 63);
                default: xs = 64'd0 - ({$urandom, $urandom} >> $urandom_range(1, 63));
            endcase
            send(6'($urandom), $urandom, $urandom, {$urandom, $urandom}, xs, w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
